risc_v_ctrl_fsm: RTL and testbench

RISC_V_CTRL_FSM -- requirements
Module: risc_v_ctrl_fsm

---
 rtl/risc_v_ctrl_fsm_pkg.sv | 61 ++++++
 rtl/risc_v_fpu_watchdog.sv | 32 +++
 rtl/risc_v_ctrl_fsm.sv | 198 +++++++++++++++++++
 tb/tb_risc_v_ctrl_fsm.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM: state encoding,
// opcode constants and the datapath select encodings.
package risc_v_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_FPEXEC   = 4'd11,
    S_FPWB     = 4'd12
  } state_t;

  // Opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_FSW = 7'b0100111;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_FP  = 7'b1010011;

  // Immediate-extender select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result multiplexer select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // True for integer and FP store opcodes.
  function automatic logic is_store(input logic [6:0] op);
    return (op == OP_SW) || (op == OP_FSW);
  endfunction

endpackage

// File: rtl/risc_v_fpu_watchdog.sv
// Cycle counter bounding the time spent waiting for the FPU. The count is
// zero in the first FPEXEC cycle and returns to zero whenever FPEXEC is left.
module risc_v_fpu_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_first,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count while staying in FPEXEC, clear otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= {CW{1'b0}};
    end else if (i_run && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= {CW{1'b0}};
    end
  end

  assign o_first   = (r_count == {CW{1'b0}});
  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/risc_v_ctrl_fsm.sv
// Multicycle RISC-V control unit with a bounded multi-cycle FPU wait.
// Outputs are decoded from the state (BRANCH's PCWrite follows Zero) and
// are forced low while RST is high.
module risc_v_ctrl_fsm
  import risc_v_ctrl_fsm_pkg::*;
#(
  parameter int FPU_TIMEOUT = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  input  logic       fpu_done,
  output logic [1:0] ImmSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       RegWrite,
  output logic       FRegWrite,
  output logic       fpu_start,
  output logic       illegal,
  output logic       fpu_timeout,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp
);

  state_t r_state;
  state_t w_state_next;
  logic   w_fpu_run;
  logic   w_fpu_first;
  logic   w_fpu_expired;

  assign w_fpu_run = (r_state == S_FPEXEC) && (w_state_next == S_FPEXEC);

  risc_v_fpu_watchdog #(.TIMEOUT(FPU_TIMEOUT)) u_watchdog (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_run     (w_fpu_run),
    .o_first   (w_fpu_first),
    .o_expired (w_fpu_expired)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; each state only listens to its own handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_FLW, OP_SW, OP_FSW: w_state_next = S_MEMADR;
          OP_R:                         w_state_next = S_EXECR;
          OP_I:                         w_state_next = S_EXECI;
          OP_BEQ:                       w_state_next = S_BRANCH;
          OP_JAL:                       w_state_next = S_JAL;
          OP_FP:                        w_state_next = S_FPEXEC;
          default:                      w_state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (is_store(opcode)) begin
          w_state_next = S_MEMWRITE;
        end else begin
          w_state_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          w_state_next = S_MEMWB;
        end else begin
          w_state_next = S_MEMREAD;
        end
      end
      S_MEMWB:  w_state_next = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_MEMWRITE;
        end
      end
      S_EXECR:  w_state_next = S_ALUWB;
      S_EXECI:  w_state_next = S_ALUWB;
      S_ALUWB:  w_state_next = S_FETCH;
      S_BRANCH: w_state_next = S_FETCH;
      S_JAL:    w_state_next = S_ALUWB;
      S_FPEXEC: begin
        if (fpu_done) begin
          w_state_next = S_FPWB;
        end else if (w_fpu_expired) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_FPEXEC;
        end
      end
      S_FPWB:   w_state_next = S_FETCH;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Output decode; everything not named for a state stays at zero.
  always_comb begin
    ImmSrc      = IMM_I;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    RegWrite    = 1'b0;
    FRegWrite   = 1'b0;
    fpu_start   = 1'b0;
    illegal     = 1'b0;
    fpu_timeout = 1'b0;
    if (RST) begin
      ImmSrc = IMM_I;
    end else begin
      case (r_state)
        S_FETCH: begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          AdrSrc    = 1'b0;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
        end
        S_DECODE: begin
          ImmSrc = IMM_B;
          case (opcode)
            OP_LW, OP_FLW, OP_SW, OP_FSW, OP_R, OP_I,
            OP_BEQ, OP_JAL, OP_FP: illegal = 1'b0;
            default:               illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          if (is_store(opcode)) begin
            ImmSrc = IMM_S;
          end else begin
            ImmSrc = IMM_I;
          end
        end
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          if (opcode == OP_FLW) begin
            FRegWrite = 1'b1;
          end else begin
            RegWrite = 1'b1;
          end
        end
        S_MEMWRITE: MemWrite = 1'b1;
        S_EXECR:    ALUOp = ALUOP_FUNCT;
        S_EXECI: begin
          ALUOp  = ALUOP_FUNCT;
          ImmSrc = IMM_I;
        end
        S_ALUWB: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_ALUOUT;
        end
        S_BRANCH: begin
          ALUOp   = ALUOP_SUB;
          PCWrite = Zero;
        end
        S_JAL: begin
          ImmSrc  = IMM_J;
          PCWrite = 1'b1;
        end
        S_FPEXEC: begin
          fpu_start   = w_fpu_first;
          fpu_timeout = w_fpu_expired && !fpu_done;
        end
        S_FPWB:  FRegWrite = 1'b1;
        default: illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_ctrl_fsm.sv
// Directed scoreboard bench for risc_v_ctrl_fsm: each cycle the expected
// state and output vector are queued when inputs are driven, then popped
// and compared at the falling edge.
module tb_risc_v_ctrl_fsm;
  import risc_v_ctrl_fsm_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] opcode;
  logic       Zero, mem_ready, fpu_done;
  logic [1:0] ImmSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       PCWrite, IRWrite, AdrSrc, MemWrite, MemRead, RegWrite, FRegWrite;
  logic       fpu_start, illegal, fpu_timeout;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  risc_v_ctrl_fsm #(.FPU_TIMEOUT(32)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .Zero(Zero),
    .mem_ready(mem_ready), .fpu_done(fpu_done),
    .ImmSrc(ImmSrc), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite),
    .FRegWrite(FRegWrite), .fpu_start(fpu_start), .illegal(illegal),
    .fpu_timeout(fpu_timeout), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp)
  );

  // Strobe bit positions in the packed output vector
  localparam logic [9:0] B_PCW = 10'b1000000000;
  localparam logic [9:0] B_IRW = 10'b0100000000;
  localparam logic [9:0] B_ADR = 10'b0010000000;
  localparam logic [9:0] B_MW  = 10'b0001000000;
  localparam logic [9:0] B_MR  = 10'b0000100000;
  localparam logic [9:0] B_RW  = 10'b0000010000;
  localparam logic [9:0] B_FRW = 10'b0000001000;
  localparam logic [9:0] B_FST = 10'b0000000100;
  localparam logic [9:0] B_ILL = 10'b0000000010;
  localparam logic [9:0] B_FTO = 10'b0000000001;

  logic [19:0] w_obs;
  assign w_obs = {ImmSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                  PCWrite, IRWrite, AdrSrc, MemWrite, MemRead,
                  RegWrite, FRegWrite, fpu_start, illegal, fpu_timeout};

  typedef struct {
    string       tag;
    state_t      st;
    logic [19:0] outs;
  } exp_t;

  exp_t sb[$];

  function automatic logic [19:0] mk(input logic [1:0] imm, input logic [1:0] res,
                                     input logic [1:0] sa, input logic [1:0] sb_,
                                     input logic [1:0] aop, input logic [9:0] strb);
    return {imm, res, sa, sb_, aop, strb};
  endfunction

  logic [19:0] E_ZERO, E_FETCH, E_DEC, E_MEMADR_S, E_MEMREAD, E_MEMWB_I, E_MEMWB_F;
  logic [19:0] E_MEMWRITE, E_EXECR, E_EXECI, E_ALUWB, E_BR_T, E_BR_N, E_JAL;
  logic [19:0] E_FPSTART, E_FPTO, E_FPWB, E_ILL;

  // Queue this cycle's expectation, compare at the falling edge, then move
  // to just after the next rising edge where the caller drives new inputs.
  task automatic cyc(input string tag, input state_t st, input logic [19:0] outs);
    exp_t e;
    sb.push_back('{tag, st, outs});
    @(negedge CLK);
    e = sb.pop_front();
    checks++;
    assert (w_obs === e.outs) else begin
      failures++;
      $error("FAIL %s outputs: got %h expected %h", e.tag, w_obs, e.outs);
    end
    checks++;
    assert (dut.r_state === e.st) else begin
      failures++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, dut.r_state, e.st);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    E_ZERO     = 20'd0;
    E_FETCH    = mk(2'b00, 2'b10, 2'b00, 2'b10, 2'b00, B_PCW | B_IRW);
    E_DEC      = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0);
    E_ILL      = mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, B_ILL);
    E_MEMADR_S = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 10'd0);
    E_MEMREAD  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, B_ADR | B_MR);
    E_MEMWB_I  = mk(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, B_RW);
    E_MEMWB_F  = mk(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, B_FRW);
    E_MEMWRITE = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, B_MW);
    E_EXECR    = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 10'd0);
    E_EXECI    = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 10'd0);
    E_ALUWB    = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, B_RW);
    E_BR_T     = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, B_PCW);
    E_BR_N     = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 10'd0);
    E_JAL      = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, B_PCW);
    E_FPSTART  = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, B_FST);
    E_FPTO     = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, B_FTO);
    E_FPWB     = mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, B_FRW);

    RST = 1'b1; opcode = OP_R; Zero = 1'b0; mem_ready = 1'b0; fpu_done = 1'b0;
    @(posedge CLK);
    #1;
    // Second reset edge happens inside this step; outputs forced low.
    cyc("reset", S_FETCH, E_ZERO);
    RST = 1'b0;

    // R-type: RegWrite only in the fourth cycle
    cyc("r_fetch", S_FETCH, E_FETCH);
    cyc("r_decode", S_DECODE, E_DEC);
    cyc("r_exec", S_EXECR, E_EXECR);
    cyc("r_aluwb", S_ALUWB, E_ALUWB);

    // lw with five wait cycles; a stray fpu_done is ignored in MEMREAD
    opcode = OP_LW;
    cyc("lw_fetch", S_FETCH, E_FETCH);
    cyc("lw_decode", S_DECODE, E_DEC);
    cyc("lw_memadr", S_MEMADR, E_ZERO);
    for (int i = 0; i < 5; i++) begin
      fpu_done = (i == 2) ? 1'b1 : 1'b0;
      cyc("lw_wait", S_MEMREAD, E_MEMREAD);
    end
    fpu_done = 1'b0; mem_ready = 1'b1;
    cyc("lw_ready", S_MEMREAD, E_MEMREAD);
    mem_ready = 1'b0;
    cyc("lw_wb", S_MEMWB, E_MEMWB_I);

    // flw with mem_ready in the entry cycle of MEMREAD
    opcode = OP_FLW;
    cyc("flw_fetch", S_FETCH, E_FETCH);
    cyc("flw_decode", S_DECODE, E_DEC);
    cyc("flw_memadr", S_MEMADR, E_ZERO);
    mem_ready = 1'b1;
    cyc("flw_read", S_MEMREAD, E_MEMREAD);
    mem_ready = 1'b0;
    cyc("flw_wb", S_MEMWB, E_MEMWB_F);

    // fsw completing immediately
    opcode = OP_FSW;
    cyc("fsw_fetch", S_FETCH, E_FETCH);
    cyc("fsw_decode", S_DECODE, E_DEC);
    cyc("fsw_memadr", S_MEMADR, E_MEMADR_S);
    mem_ready = 1'b1;
    cyc("fsw_write", S_MEMWRITE, E_MEMWRITE);
    mem_ready = 1'b0;

    // sw abandoned by reset in MEMWRITE
    opcode = OP_SW;
    cyc("sw_fetch", S_FETCH, E_FETCH);
    cyc("sw_decode", S_DECODE, E_DEC);
    cyc("sw_memadr", S_MEMADR, E_MEMADR_S);
    cyc("sw_write", S_MEMWRITE, E_MEMWRITE);
    RST = 1'b1;
    cyc("sw_rst", S_MEMWRITE, E_ZERO);
    RST = 1'b0;
    cyc("sw_after_rst", S_FETCH, E_FETCH);

    // beq taken, then not taken
    opcode = OP_BEQ; Zero = 1'b1;
    cyc("beq_decode", S_DECODE, E_DEC);
    cyc("beq_taken", S_BRANCH, E_BR_T);
    Zero = 1'b0;
    cyc("beq_fetch", S_FETCH, E_FETCH);
    cyc("beq_decode2", S_DECODE, E_DEC);
    cyc("beq_not_taken", S_BRANCH, E_BR_N);

    // jal
    opcode = OP_JAL;
    cyc("jal_fetch", S_FETCH, E_FETCH);
    cyc("jal_decode", S_DECODE, E_DEC);
    cyc("jal_jal", S_JAL, E_JAL);
    cyc("jal_aluwb", S_ALUWB, E_ALUWB);

    // I-ALU
    opcode = OP_I;
    cyc("i_fetch", S_FETCH, E_FETCH);
    cyc("i_decode", S_DECODE, E_DEC);
    cyc("i_exec", S_EXECI, E_EXECI);
    cyc("i_aluwb", S_ALUWB, E_ALUWB);

    // OP-FP without fpu_done: 32 cycles in FPEXEC, timeout in the last one.
    // A stray mem_ready is ignored while waiting.
    opcode = OP_FP;
    cyc("fpto_fetch", S_FETCH, E_FETCH);
    cyc("fpto_decode", S_DECODE, E_DEC);
    cyc("fpto_start", S_FPEXEC, E_FPSTART);
    for (int i = 1; i < 31; i++) begin
      mem_ready = (i == 5) ? 1'b1 : 1'b0;
      cyc("fpto_wait", S_FPEXEC, E_ZERO);
    end
    mem_ready = 1'b0;
    cyc("fpto_timeout", S_FPEXEC, E_FPTO);
    cyc("fpto_fetch2", S_FETCH, E_FETCH);

    // OP-FP completing on fpu_done
    cyc("fp_decode", S_DECODE, E_DEC);
    cyc("fp_start", S_FPEXEC, E_FPSTART);
    cyc("fp_wait", S_FPEXEC, E_ZERO);
    fpu_done = 1'b1;
    cyc("fp_done", S_FPEXEC, E_ZERO);
    fpu_done = 1'b0;
    cyc("fp_wb", S_FPWB, E_FPWB);

    // Illegal opcode
    opcode = 7'b1111111;
    cyc("ill_fetch", S_FETCH, E_FETCH);
    cyc("ill_decode", S_DECODE, E_ILL);
    cyc("ill_back", S_FETCH, E_FETCH);
    cyc("ill_decode2", S_DECODE, E_ILL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
